control_pipe: RTL and testbench

ID-stage control unit with an integrated ID/EX control register for the pipelined MIPS core with L2 cache. It decodes the instruction in ID into the datapath control bundle and registers that bundle for EX. It also detects load-use hazards and inserts a parameterised number of bubbles, absorbs cache stalls, and accepts branch/jump flushes. It sits between the IF/ID register and the EX stage and drives `stall_o` back to the PC and IF/ID enables.

---
 rtl/control_pipe.sv | 247 ++++++++++++++++++++++++
 tb/tb_control_pipe.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// ID-stage decoder plus ID/EX control register; load-use bubbles only when CTRL_HAZARD_EN is defined.
// Latency: the instruction in ID appears on the registered bundle after one clock edge.
// Backpressure: mem_stall_i freezes all state; stall_o holds PC and IF/ID while bubbles drain.
module control_pipe #(
    parameter int ALU_W        = 4,
    parameter int LOAD_USE_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction_i,
    input  logic             mem_stall_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [1:0]       RegDst_o,
    output logic [1:0]       Jump_o,
    output logic             Brncheq_o,
    output logic             Brnchne_o,
    output logic [1:0]       CachetoReg_o,
    output logic [ALU_W-1:0] ALU_control_o,
    output logic             CacheRead_o,
    output logic             CacheWrite_o,
    output logic             ALUSrc_o,
    output logic             RegWrite_o,
    output logic [4:0]       ex_dst_o
);
    typedef struct packed {
        logic [1:0]       reg_dst;
        logic [1:0]       jump;
        logic             brncheq;
        logic             brnchne;
        logic [1:0]       cache_to_reg;
        logic [ALU_W-1:0] alu;
        logic             cache_read;
        logic             cache_write;
        logic             alu_src;
        logic             reg_write;
    } ctrl_t;

    localparam logic [ALU_W-1:0] ALU_AND  = ALU_W'(0);
    localparam logic [ALU_W-1:0] ALU_OR   = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_ADD  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_SUB  = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_SLT  = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_SLL  = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SRL  = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SRA  = ALU_W'(7);
    localparam logic [ALU_W-1:0] ALU_XOR  = ALU_W'(8);
    localparam logic [ALU_W-1:0] ALU_NOR  = ALU_W'(9);
    localparam logic [ALU_W-1:0] ALU_NONE = '1;
    localparam ctrl_t            BUBBLE   = '{alu: ALU_NONE, default: '0};

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       valid;
    logic       rd_rs;
    logic       rd_rt;
    ctrl_t      dec;
    logic [4:0] dec_dst;
    ctrl_t      ctrl_q;
    logic [4:0] ex_dst_q;
    logic       unused_shamt;

    assign opcode       = instruction_i[31:26];
    assign rs           = instruction_i[25:21];
    assign rt           = instruction_i[20:16];
    assign rd           = instruction_i[15:11];
    assign funct        = instruction_i[5:0];
    assign unused_shamt = ^instruction_i[10:6];

    always_comb begin
        dec     = '0;
        valid   = 1'b1;
        rd_rs   = 1'b1;
        rd_rt   = 1'b0;
        dec_dst = 5'd0;
        if (instruction_i == 32'h0) begin
            valid = 1'b0;
        end else begin
            case (opcode)
                6'h00: begin
                    rd_rt = 1'b1;
                    case (funct)
                        6'h08: begin
                            dec.jump         = 2'b10;
                            dec.reg_dst      = 2'b11;
                            dec.cache_to_reg = 2'b11;
                        end
                        6'h09: begin
                            dec.jump         = 2'b10;
                            dec.reg_dst      = 2'b01;
                            dec.cache_to_reg = 2'b11;
                            dec.reg_write    = 1'b1;
                        end
                        default: begin
                            dec.reg_dst   = 2'b01;
                            dec.reg_write = 1'b1;
                            case (funct)
                                6'h00:   dec.alu = ALU_SLL;
                                6'h02:   dec.alu = ALU_SRL;
                                6'h03:   dec.alu = ALU_SRA;
                                6'h20:   dec.alu = ALU_ADD;
                                6'h22:   dec.alu = ALU_SUB;
                                6'h24:   dec.alu = ALU_AND;
                                6'h25:   dec.alu = ALU_OR;
                                6'h26:   dec.alu = ALU_XOR;
                                6'h27:   dec.alu = ALU_NOR;
                                6'h2a:   dec.alu = ALU_SLT;
                                default: valid   = 1'b0;
                            endcase
                        end
                    endcase
                end
                6'h02: begin
                    rd_rs            = 1'b0;
                    dec.jump         = 2'b01;
                    dec.reg_dst      = 2'b11;
                    dec.cache_to_reg = 2'b11;
                end
                6'h03: begin
                    rd_rs            = 1'b0;
                    dec.jump         = 2'b01;
                    dec.reg_dst      = 2'b10;
                    dec.cache_to_reg = 2'b10;
                    dec.reg_write    = 1'b1;
                end
                6'h04, 6'h05: begin
                    rd_rt            = 1'b1;
                    dec.brncheq      = (opcode == 6'h04);
                    dec.brnchne      = (opcode == 6'h05);
                    dec.reg_dst      = 2'b11;
                    dec.cache_to_reg = 2'b11;
                end
                6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e: begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    case (opcode)
                        6'h08:   dec.alu = ALU_ADD;
                        6'h0a:   dec.alu = ALU_SLT;
                        6'h0c:   dec.alu = ALU_AND;
                        6'h0d:   dec.alu = ALU_OR;
                        default: dec.alu = ALU_XOR;
                    endcase
                end
                6'h23: begin
                    dec.cache_to_reg = 2'b01;
                    dec.alu          = ALU_ADD;
                    dec.cache_read   = 1'b1;
                    dec.alu_src      = 1'b1;
                    dec.reg_write    = 1'b1;
                end
                6'h2b: begin
                    rd_rt            = 1'b1;
                    dec.reg_dst      = 2'b11;
                    dec.cache_to_reg = 2'b11;
                    dec.alu          = ALU_ADD;
                    dec.cache_write  = 1'b1;
                    dec.alu_src      = 1'b1;
                end
                default: valid = 1'b0;
            endcase
        end
        // An undecodable word must look exactly like a bubble, destination included.
        if (!valid) begin
            dec   = BUBBLE;
            rd_rs = 1'b0;
            rd_rt = 1'b0;
        end else begin
            case (dec.reg_dst)
                2'b00:   dec_dst = rt;
                2'b01:   dec_dst = rd;
                2'b10:   dec_dst = 5'd31;
                default: dec_dst = 5'd0;
            endcase
        end
    end

`ifdef CTRL_HAZARD_EN
    logic [1:0] cnt;
    logic       hazard;

    assign hazard  = ctrl_q.cache_read && (ex_dst_q != 5'd0) &&
                     ((rd_rs && (rs == ex_dst_q)) || (rd_rt && (rt == ex_dst_q)));
    assign stall_o = !flush_i && ((hazard && (cnt == 2'd0)) || (cnt != 2'd0));

    // The first bubble clears the load from EX, so cnt carries the remaining ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= BUBBLE;
            ex_dst_q <= 5'd0;
            cnt      <= 2'd0;
        end else if (!mem_stall_i) begin
            if (flush_i) begin
                ctrl_q   <= BUBBLE;
                ex_dst_q <= 5'd0;
                cnt      <= 2'd0;
            end else if (hazard && (cnt == 2'd0)) begin
                ctrl_q   <= BUBBLE;
                ex_dst_q <= 5'd0;
                cnt      <= 2'(LOAD_USE_LAT - 1);
            end else if (cnt != 2'd0) begin
                ctrl_q   <= BUBBLE;
                ex_dst_q <= 5'd0;
                cnt      <= cnt - 2'd1;
            end else begin
                ctrl_q   <= dec;
                ex_dst_q <= dec_dst;
            end
        end
    end
`else
    logic unused_hz;

    assign unused_hz = ^{rd_rs, rd_rt, rs};
    assign stall_o   = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q   <= BUBBLE;
            ex_dst_q <= 5'd0;
        end else if (!mem_stall_i) begin
            if (flush_i) begin
                ctrl_q   <= BUBBLE;
                ex_dst_q <= 5'd0;
            end else begin
                ctrl_q   <= dec;
                ex_dst_q <= dec_dst;
            end
        end
    end
`endif

    assign RegDst_o      = ctrl_q.reg_dst;
    assign Jump_o        = ctrl_q.jump;
    assign Brncheq_o     = ctrl_q.brncheq;
    assign Brnchne_o     = ctrl_q.brnchne;
    assign CachetoReg_o  = ctrl_q.cache_to_reg;
    assign ALU_control_o = ctrl_q.alu;
    assign CacheRead_o   = ctrl_q.cache_read;
    assign CacheWrite_o  = ctrl_q.cache_write;
    assign ALUSrc_o      = ctrl_q.alu_src;
    assign RegWrite_o    = ctrl_q.reg_write;
    assign ex_dst_o      = ex_dst_q;

endmodule

// File: tb/tb_control_pipe.sv
// Bench for control_pipe: directed scenarios then random instruction streams against a decode-table model.
`timescale 1ns/1ps
module tb_control_pipe;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        ms;
    logic        fl;
    logic        stall_o;
    logic [1:0]  RegDst_o, Jump_o, CachetoReg_o;
    logic        Brncheq_o, Brnchne_o, CacheRead_o, CacheWrite_o, ALUSrc_o, RegWrite_o;
    logic [3:0]  ALU_control_o;
    logic [4:0]  ex_dst_o;

    always #5 clk = ~clk;

    control_pipe #(.ALU_W(4), .LOAD_USE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .instruction_i(instr), .mem_stall_i(ms), .flush_i(fl),
        .stall_o(stall_o), .RegDst_o(RegDst_o), .Jump_o(Jump_o), .Brncheq_o(Brncheq_o),
        .Brnchne_o(Brnchne_o), .CachetoReg_o(CachetoReg_o), .ALU_control_o(ALU_control_o),
        .CacheRead_o(CacheRead_o), .CacheWrite_o(CacheWrite_o), .ALUSrc_o(ALUSrc_o),
        .RegWrite_o(RegWrite_o), .ex_dst_o(ex_dst_o)
    );

    typedef struct packed {
        logic [1:0] rd;
        logic [1:0] jmp;
        logic       beq;
        logic       bne;
        logic [1:0] c2r;
        logic [3:0] alu;
        logic       cr;
        logic       cw;
        logic       asrc;
        logic       rw;
        logic [4:0] dst;
    } bund_t;

    localparam bund_t BUB = '{alu: 4'hf, default: '0};

    bund_t obs;
    assign obs = {RegDst_o, Jump_o, Brncheq_o, Brnchne_o, CachetoReg_o, ALU_control_o,
                  CacheRead_o, CacheWrite_o, ALUSrc_o, RegWrite_o, ex_dst_o};

    int    n_checks = 0;
    int    n_pass   = 0;
    bund_t m;
    int    pend;

    logic [5:0] rfn [10] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
    logic [5:0] iop [5]  = '{6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    // ALU code of an R-type funct, -1 when the funct is not an ALU op.
    function automatic int r_alu(input logic [5:0] fn);
        case (fn)
            6'h00: return 5;  6'h02: return 6;  6'h03: return 7;
            6'h20: return 2;  6'h22: return 3;  6'h24: return 0;
            6'h25: return 1;  6'h26: return 8;  6'h27: return 9;
            6'h2a: return 4;  default: return -1;
        endcase
    endfunction

    function automatic bund_t ref_dec(input logic [31:0] i, output logic rs_u, output logic rt_u);
        bund_t b;
        logic  ok;
        logic [5:0] op;
        logic [5:0] fn;
        b = '0; ok = 1'b1; rs_u = 1'b1; rt_u = 1'b0;
        op = i[31:26]; fn = i[5:0];
        if (i == 32'h0) ok = 1'b0;
        else case (op)
            6'h00: begin
                rt_u = 1'b1;
                if (fn == 6'h08) begin b.jmp = 2; b.rd = 3; b.c2r = 3; end
                else if (fn == 6'h09) begin b.jmp = 2; b.rd = 1; b.c2r = 3; b.rw = 1; end
                else if (r_alu(fn) >= 0) begin b.rd = 1; b.rw = 1; b.alu = 4'(r_alu(fn)); end
                else ok = 1'b0;
            end
            6'h02: begin rs_u = 0; b.jmp = 1; b.rd = 3; b.c2r = 3; end
            6'h03: begin rs_u = 0; b.jmp = 1; b.rd = 2; b.c2r = 2; b.rw = 1; end
            6'h04: begin rt_u = 1; b.beq = 1; b.rd = 3; b.c2r = 3; end
            6'h05: begin rt_u = 1; b.bne = 1; b.rd = 3; b.c2r = 3; end
            6'h08: begin b.asrc = 1; b.rw = 1; b.alu = 2; end
            6'h0a: begin b.asrc = 1; b.rw = 1; b.alu = 4; end
            6'h0c: begin b.asrc = 1; b.rw = 1; b.alu = 0; end
            6'h0d: begin b.asrc = 1; b.rw = 1; b.alu = 1; end
            6'h0e: begin b.asrc = 1; b.rw = 1; b.alu = 8; end
            6'h23: begin b.c2r = 1; b.alu = 2; b.cr = 1; b.asrc = 1; b.rw = 1; end
            6'h2b: begin rt_u = 1; b.rd = 3; b.c2r = 3; b.alu = 2; b.cw = 1; b.asrc = 1; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            rs_u = 0; rt_u = 0;
            return BUB;
        end
        b.dst = (b.rd == 0) ? i[20:16] : (b.rd == 1) ? i[15:11] : (b.rd == 2) ? 5'd31 : 5'd0;
        return b;
    endfunction

    // One ID cycle: called at posedge+1, checks stall mid-cycle and the bundle after the edge.
    task automatic step(input logic [31:0] ins, input logic s, input logic f, input string tag);
        logic  rsu, rtu, hz, exp_stall;
        bund_t d;
        instr = ins; ms = s; fl = f;
        d = ref_dec(ins, rsu, rtu);
`ifdef CTRL_HAZARD_EN
        hz = m.cr && (m.dst != 0) && ((rsu && ins[25:21] == m.dst) || (rtu && ins[20:16] == m.dst));
`else
        hz = 1'b0;
`endif
        exp_stall = !f && ((hz && pend == 0) || pend != 0);
        #4;
        chk({tag, "_stall"}, {31'b0, stall_o}, {31'b0, exp_stall});
        @(posedge clk);
        if (!s) begin
            if (f) begin m = BUB; pend = 0; end
            else if (hz && pend == 0) begin m = BUB; pend = LAT - 1; end
            else if (pend != 0) begin m = BUB; pend--; end
            else m = d;
        end
        #1;
        chk({tag, "_bundle"}, {11'b0, obs}, {11'b0, m});
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [4:0] a, b, c;
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 11))
            0:       return {6'h00, a, b, c, 5'($urandom), rfn[$urandom_range(0, 9)]};
            1:       return {6'h00, a, 15'b0, 6'h08};
            2:       return {6'h00, a, 5'b0, c, 5'b0, 6'h09};
            3:       return {6'h02, 26'($urandom)};
            4:       return {6'h03, 26'($urandom)};
            5:       return {5'b00010, 1'($urandom), a, b, 16'($urandom)};
            6:       return {iop[$urandom_range(0, 4)], a, b, 16'($urandom)};
            7, 8:    return {6'h23, a, b, 16'($urandom)};
            9:       return {6'h2b, a, b, 16'($urandom)};
            10:      return {6'h00, a, b, c, 5'b0, 6'($urandom)};
            default: return ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        endcase
    endfunction

    initial begin
        rst = 1'b1; instr = 32'h0; ms = 1'b0; fl = 1'b0;
        m = BUB; pend = 0;
        @(posedge clk);
        #1;
        chk("reset_bundle", {11'b0, obs}, {11'b0, BUB});
        chk("reset_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        step(32'h00221820, 0, 0, "add3");
        chk("add3_dst", {27'b0, ex_dst_o}, 32'd3);
        chk("add3_alu", {28'b0, ALU_control_o}, 32'd2);

        step(32'h8c240000, 0, 0, "lw4");
        for (int k = 0; k < 3; k++) step(32'h00842820, 0, 0, "add5_dep");

        step(32'h8c240000, 0, 0, "lw4_ms");
        step(32'h00842820, 0, 0, "add5_b1");
        for (int k = 0; k < 3; k++) step(32'h00842820, 1, 0, "add5_frozen");
        for (int k = 0; k < 2; k++) step(32'h00842820, 0, 0, "add5_resume");

        step(32'h0c000100, 0, 0, "jal");
        chk("jal_dst", {27'b0, ex_dst_o}, 32'd31);
        step(32'hac240000, 0, 1, "sw_flush");

        step(32'h8c240000, 0, 0, "lw4_j");
        step(32'h08000040, 0, 0, "j_nodep");
        step(32'h8c240000, 0, 0, "lw4_fl");
        step(32'h00842820, 0, 1, "add5_flushwins");
        step(32'h00842820, 0, 0, "add5_after_fl");

        step(32'hfc000000, 0, 0, "undef3f");

        step(32'h8c240000, 0, 0, "lw4_rst");
        step(32'h00842820, 0, 0, "add5_hz");
        rst = 1'b1;
        #1;
        m = BUB; pend = 0;
        chk("midrst_bundle", {11'b0, obs}, {11'b0, BUB});
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        step(32'h00842820, 0, 0, "add5_postrst");

        for (int k = 0; k < 400; k++)
            step(rnd_instr(), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) == 0), "rnd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
